// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage valid/ready register chain with flush, bubble collapse and RAW hazard lookup
module pipe_reg_chain #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 3,
    parameter int RD_LSB = 0,
    parameter int WE_BIT = 5
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    input  logic [DEPTH-1:0]           flush_mask,
    input  logic [4:0]                 q_rs1,
    input  logic [4:0]                 q_rs2,
    output logic [DEPTH-1:0]           haz_stage,
    output logic                       haz_any,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [CW-1:0]    count_d;
    logic [4:0]       rd;

    // A stage may load when it is empty or the stage ahead of it moves; empty stages collapse.
    always_comb begin
        rdy = '0;
        rdy[DEPTH-1] = !valid_q[DEPTH-1] || out_ready;
        for (int k = DEPTH-2; k >= 0; k--) begin
            rdy[k] = !valid_q[k] || rdy[k+1];
        end
    end

    // Flush only clears what lands in a stage; it never gates the ready chain.
    always_comb begin
        valid_d = valid_q;
        if (rdy[0]) begin
            valid_d[0] = in_valid;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
                valid_d[k] = valid_q[k-1];
            end
        end
        valid_d = valid_d & ~flush_mask;
        count_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_d = count_d + CW'(valid_d[k]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            count   <= '0;
        end else begin
            valid_q <= valid_d;
            count   <= count_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rdy[0]) begin
            data_q[0] <= in_data;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
                data_q[k] <= data_q[k-1];
            end
        end
    end

    always_comb begin
        rd        = '0;
        haz_stage = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rd           = data_q[k][RD_LSB +: 5];
            haz_stage[k] = valid_q[k] && data_q[k][WE_BIT] && (rd != 5'd0) &&
                           ((rd == q_rs1) || (rd == q_rs2));
        end
    end

    assign haz_any   = |haz_stage;
    assign in_ready  = rdy[0];
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - directed-vector bench for pipe_reg_chain (DEPTH=3, WIDTH=64)
module tb_pipe_reg_chain;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [2:0]  flush_mask;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic [2:0]  haz_stage;
    logic        haz_any;
    logic [1:0]  count;

    int nvec;
    int nfail;

    pipe_reg_chain #(.WIDTH(64), .DEPTH(3), .RD_LSB(0), .WE_BIT(5)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .flush_mask(flush_mask), .q_rs1(q_rs1), .q_rs2(q_rs2),
        .haz_stage(haz_stage), .haz_any(haz_any), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 0; out_ready = 0; flush_mask = 3'b111;
        cyc();
        flush_mask = 3'b000;
        nvec++; if (count !== 2'd0) begin nfail++; $display("FAIL drain_count: got %0d expected 0", count); end
    endtask

    task automatic test_reset();
        rstn = 0; in_valid = 0; in_data = 0; out_ready = 0; flush_mask = 0; q_rs1 = 0; q_rs2 = 0;
        #2;
        nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
        nvec++; if (haz_any !== 1'b0) begin nfail++; $display("FAIL rst_haz_any: got %0b expected 0", haz_any); end
        nvec++; if (haz_stage !== 3'b000) begin nfail++; $display("FAIL rst_haz_stage: got %0b expected 000", haz_stage); end
        nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
        nvec++; if (count !== 2'd0) begin nfail++; $display("FAIL rst_count: got %0d expected 0", count); end
        in_valid = 1; in_data = 64'h5;
        cyc(); cyc();
        nvec++; if (out_valid !== 1'b0 || count !== 2'd0) begin nfail++; $display("FAIL rst_hold: got out_valid=%0b count=%0d expected 0/0", out_valid, count); end
        in_valid = 0;
        #3 rstn = 1;
        cyc();
        nvec++; if (count !== 2'd0) begin nfail++; $display("FAIL rst_release_count: got %0d expected 0", count); end
    endtask

    task automatic test_stream();
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            in_data  = 64'(i + 1);
            #1;
            nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, in_ready); end
            cyc();
            if (i + 1 == 3) begin
                nvec++; if (count !== 2'd3) begin nfail++; $display("FAIL stream_count: got %0d expected 3", count); end
            end
            if (i + 1 >= 3) begin
                nvec++; if (out_valid !== 1'b1 || out_data !== 64'(i - 1)) begin nfail++; $display("FAIL stream_out[%0d]: got v=%0b d=%0h expected v=1 d=%0h", i + 1, out_valid, out_data, i - 1); end
            end else begin
                nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL stream_early[%0d]: got %0b expected 0", i + 1, out_valid); end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = 64'(10 + i);
            #1;
            nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL fill_in_ready[%0d]: got %0b expected 1", i, in_ready); end
            cyc();
        end
        in_valid = 1; in_data = 64'd13;
        #1;
        nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL full_in_ready: got %0b expected 0", in_ready); end
        nvec++; if (count !== 2'd3) begin nfail++; $display("FAIL full_count: got %0d expected 3", count); end
        nvec++; if (out_valid !== 1'b1 || out_data !== 64'd10) begin nfail++; $display("FAIL full_head: got v=%0b d=%0h expected v=1 d=a", out_valid, out_data); end
        out_ready = 1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL pop_in_ready: got %0b expected 1", in_ready); end
        cyc();
        out_ready = 0; in_valid = 0;
        #1;
        nvec++; if (out_data !== 64'd11 || count !== 2'd3 || in_ready !== 1'b0) begin nfail++; $display("FAIL one_pop: got d=%0h count=%0d rdy=%0b expected d=b count=3 rdy=0", out_data, count, in_ready); end
        out_ready = 1;
        cyc();
        nvec++; if (out_data !== 64'd12) begin nfail++; $display("FAIL order_12: got %0h expected c", out_data); end
        cyc();
        nvec++; if (out_data !== 64'd13) begin nfail++; $display("FAIL order_13: got %0h expected d", out_data); end
        cyc();
        nvec++; if (out_valid !== 1'b0 || count !== 2'd0) begin nfail++; $display("FAIL order_empty: got v=%0b count=%0d expected 0/0", out_valid, count); end
        out_ready = 0;
    endtask

    task automatic test_bubble();
        out_ready = 0; q_rs1 = 5'd3; q_rs2 = 5'd4;
        in_valid = 1; in_data = 64'h23;
        cyc();
        in_valid = 0;
        cyc(); cyc();
        in_valid = 1; in_data = 64'h24;
        cyc();
        nvec++; if (haz_stage !== 3'b101) begin nfail++; $display("FAIL bubble_mid: got %0b expected 101", haz_stage); end
        in_valid = 0;
        cyc();
        nvec++; if (haz_stage !== 3'b110 || haz_any !== 1'b1) begin nfail++; $display("FAIL bubble_stages: got %0b any=%0b expected 110 any=1", haz_stage, haz_any); end
        nvec++; if (count !== 2'd2) begin nfail++; $display("FAIL bubble_count: got %0d expected 2", count); end
        nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL bubble_in_ready: got %0b expected 1", in_ready); end
        nvec++; if (out_data !== 64'h23) begin nfail++; $display("FAIL bubble_head: got %0h expected 23", out_data); end
        drain();
    endtask

    task automatic test_hazard();
        out_ready = 0; in_valid = 1;
        in_data = 64'h20; cyc();
        in_data = 64'h25; cyc();
        in_data = 64'h05; cyc();
        in_valid = 0;
        q_rs1 = 5'd5; q_rs2 = 5'd0;
        #1;
        nvec++; if (count !== 2'd3) begin nfail++; $display("FAIL haz_count: got %0d expected 3", count); end
        nvec++; if (haz_stage !== 3'b010 || haz_any !== 1'b1) begin nfail++; $display("FAIL haz_rs1: got %0b any=%0b expected 010 any=1", haz_stage, haz_any); end
        q_rs1 = 5'd7;
        #1;
        nvec++; if (haz_stage !== 3'b000 || haz_any !== 1'b0) begin nfail++; $display("FAIL haz_none: got %0b any=%0b expected 000 any=0", haz_stage, haz_any); end
        q_rs2 = 5'd5;
        #1;
        nvec++; if (haz_stage !== 3'b010) begin nfail++; $display("FAIL haz_rs2: got %0b expected 010", haz_stage); end
    endtask

    task automatic test_flush();
        flush_mask = 3'b011; out_ready = 1; in_valid = 1; in_data = 64'h39;
        #1;
        nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 64'h20) begin nfail++; $display("FAIL flush_pre: got rdy=%0b v=%0b d=%0h expected 1/1/20", in_ready, out_valid, out_data); end
        cyc();
        flush_mask = 0; in_valid = 0; out_ready = 0; q_rs1 = 5'd5; q_rs2 = 5'd25;
        #1;
        nvec++; if (count !== 2'd1) begin nfail++; $display("FAIL flush_count: got %0d expected 1", count); end
        nvec++; if (haz_stage !== 3'b100) begin nfail++; $display("FAIL flush_stages: got %0b expected 100", haz_stage); end
        nvec++; if (out_data !== 64'h25) begin nfail++; $display("FAIL flush_head: got %0h expected 25", out_data); end
        flush_mask = 3'b100; out_ready = 1;
        #1;
        nvec++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL flush_deliver: got %0b expected 1", out_valid); end
        cyc();
        flush_mask = 0; out_ready = 0;
        nvec++; if (count !== 2'd0 || out_valid !== 1'b0) begin nfail++; $display("FAIL flush_empty: got count=%0d v=%0b expected 0/0", count, out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1; q_rs1 = 5'd7; q_rs2 = 5'd0;
        in_valid = 1; in_data = 64'h27;
        cyc(); cyc(); cyc();
        #2;
        nvec++; if (haz_any !== 1'b1 || out_valid !== 1'b1) begin nfail++; $display("FAIL arst_pre: got any=%0b v=%0b expected 1/1", haz_any, out_valid); end
        rstn = 0;
        #1;
        nvec++; if (out_valid !== 1'b0 || haz_any !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin nfail++; $display("FAIL arst_now: got v=%0b any=%0b count=%0d rdy=%0b expected 0/0/0/1", out_valid, haz_any, count, in_ready); end
        in_valid = 0;
        cyc();
        #2 rstn = 1;
        in_valid = 1; in_data = 64'h41;
        cyc();
        in_data = 64'h42;
        cyc();
        in_valid = 0;
        nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL arst_lat2: got %0b expected 0", out_valid); end
        cyc();
        nvec++; if (out_valid !== 1'b1 || out_data !== 64'h41) begin nfail++; $display("FAIL arst_lat3: got v=%0b d=%0h expected 1/41", out_valid, out_data); end
        cyc();
        nvec++; if (out_valid !== 1'b1 || out_data !== 64'h42) begin nfail++; $display("FAIL arst_next: got v=%0b d=%0h expected 1/42", out_valid, out_data); end
    endtask

    initial begin
        nvec = 0;
        nfail = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_hazard();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
